// File: rtl/im_loader_pkg.sv
// loader_pkg: shared constants and state encoding for the instruction-memory
// boot loader.
//   SYNC     : frame start byte
//   IM_AW    : instruction memory word-address width
//   IM_DEPTH : instruction memory depth in words
//   BOOT_PC  : fetch address of word 0
//   state_t  : loader frame-parser states
package loader_pkg;

    localparam int unsigned IM_AW    = 10;
    localparam int unsigned IM_DEPTH = 1024;
    localparam logic [7:0]  SYNC     = 8'hA5;
    localparam logic [31:0] BOOT_PC  = 32'h0000_3000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } state_t;

    // Fetch PC at which a given instruction-memory word is read.
    function automatic logic [31:0] word_pc(input logic [IM_AW-1:0] idx);
        return BOOT_PC + (32'(idx) << 2);
    endfunction

endpackage

// File: rtl/im_loader_if.sv
// im_loader_if: valid/ready byte stream feeding the boot loader.
//   in_valid : byte available (source -> loader)
//   in_data  : stream byte    (source -> loader)
//   in_ready : loader accepts a byte; transfer when in_valid && in_ready
// modport master: byte source side; modport slave: loader side.
interface im_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/im_word_packer.sv
// im_word_packer: packs accepted bytes MSB-first into 32-bit words.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart packing at byte 0 of a word
//   byte_valid : byte_in is consumed this cycle
//   byte_in    : stream byte
//   last_byte  : the next consumed byte completes a word
//   word_valid : registered one-cycle pulse, word holds the completed word
//   word       : last completed word (held between pulses)
module im_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [23:0] sh;
    logic [1:0]  cnt;

    always_comb begin
        last_byte = (cnt == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh         <= '0;
            cnt        <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                sh  <= '0;
                cnt <= '0;
            end else if (byte_valid) begin
                sh  <= {sh[15:0], byte_in};
                cnt <= cnt + 2'd1;
                if (cnt == 2'd3) begin
                    word_valid <= 1'b1;
                    word       <= {sh, byte_in};
                end
            end
        end
    end

endmodule

// File: rtl/im_loader.sv
// im_loader: framed byte-stream boot loader for the instruction memory.
// Frame: SYNC, LEN_HI, LEN_LO, LEN x 4 data bytes (MSB first), CHK where
// CHK = XOR of LEN_HI, LEN_LO and all data bytes. The CPU is held in reset
// until a complete, checksum-verified image has been written.
//   clk, reset   : clock, synchronous active-high reset
//   bus          : byte stream (in_valid, in_data, in_ready)
//   restart      : pulse, leaves DONE/ERR for IDLE
//   im_we        : instruction memory write enable, one cycle per word
//   im_addr      : word index of the write
//   im_wdata     : packed word
//   cpu_hold     : CPU reset hold
//   done         : image loaded and verified
//   error        : frame rejected
//   words_loaded : words written in the current frame
module im_loader
    import loader_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    im_loader_if.slave       bus,
    input  logic             restart,
    output logic             im_we,
    output logic [IM_AW-1:0] im_addr,
    output logic [31:0]      im_wdata,
    output logic             cpu_hold,
    output logic             done,
    output logic             error,
    output logic [IM_AW:0]   words_loaded
);

    state_t           state, nstate;
    logic             take;
    logic             clr_frame, ld_hi, ld_len, xor_en, pack_en, wr;
    logic [7:0]       len_hi;
    logic [15:0]      len_full;
    logic [IM_AW:0]   len;
    logic [IM_AW:0]   wl_inc;
    logic [7:0]       xsum;
    logic             last_byte;

    always_comb begin
        bus.in_ready = (state != ST_DONE) && (state != ST_ERR);
        cpu_hold     = (state != ST_DONE);
        done         = (state == ST_DONE);
        error        = (state == ST_ERR);
        take         = bus.in_valid && bus.in_ready;
        len_full     = {len_hi, bus.in_data};
        wl_inc       = words_loaded + 1'b1;
        wr           = pack_en && last_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate    = state;
        clr_frame = 1'b0;
        ld_hi     = 1'b0;
        ld_len    = 1'b0;
        xor_en    = 1'b0;
        pack_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (take && bus.in_data == SYNC) begin
                    clr_frame = 1'b1;
                    nstate    = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (take) begin
                    ld_hi  = 1'b1;
                    xor_en = 1'b1;
                    nstate = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (take) begin
                    xor_en = 1'b1;
                    if (len_full > 16'(IM_DEPTH)) begin
                        nstate = ST_ERR;
                    end else begin
                        ld_len = 1'b1;
                        nstate = (len_full == 16'd0) ? ST_CHECK : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (take) begin
                    xor_en  = 1'b1;
                    pack_en = 1'b1;
                    if (last_byte && wl_inc == len) nstate = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (take) nstate = (bus.in_data == xsum) ? ST_DONE : ST_ERR;
            end
            ST_DONE, ST_ERR: begin
                if (restart) nstate = ST_IDLE;
            end
            default: nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_hi       <= '0;
            len          <= '0;
            xsum         <= '0;
            words_loaded <= '0;
            im_addr      <= '0;
        end else begin
            if (clr_frame) begin
                xsum         <= '0;
                words_loaded <= '0;
            end else begin
                if (xor_en) xsum <= xsum ^ bus.in_data;
                // words_loaded steps at the same edge im_we rises, so both
                // become visible together in the write cycle.
                if (wr) begin
                    im_addr      <= words_loaded[IM_AW-1:0];
                    words_loaded <= wl_inc;
                end
            end
            if (ld_hi)  len_hi <= bus.in_data;
            if (ld_len) len    <= len_full[IM_AW:0];
        end
    end

    im_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clr_frame),
        .byte_valid (pack_en),
        .byte_in    (bus.in_data),
        .last_byte  (last_byte),
        .word_valid (im_we),
        .word       (im_wdata)
    );

endmodule

// File: tb/tb_im_loader.sv
module tb_im_loader;
    import loader_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             restart = 1'b0;
    logic             im_we;
    logic [IM_AW-1:0] im_addr;
    logic [31:0]      im_wdata;
    logic             cpu_hold, done, error;
    logic [IM_AW:0]   words_loaded;

    im_loader_if sif ();

    always #5 clk = ~clk;

    im_loader dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (sif.slave),
        .restart      (restart),
        .im_we        (im_we),
        .im_addr      (im_addr),
        .im_wdata     (im_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    int passed = 0;
    int total  = 0;

    // write log, sampled mid-cycle
    logic [IM_AW-1:0] wr_addr[$];
    logic [31:0]      wr_data[$];
    always @(negedge clk) begin
        if (!reset && im_we) begin
            wr_addr.push_back(im_addr);
            wr_data.push_back(im_wdata);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        rs;
        logic        rdy;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic        dn;
        logic        er;
        logic        hold;
        logic [10:0] wl;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [7:0] d, input logic rs,
                       input logic rdy, input logic we, input logic [9:0] addr,
                       input logic [31:0] wd, input logic dn, input logic er,
                       input logic hold, input logic [10:0] wl);
        vec_t r;
        r.v = v; r.d = d; r.rs = rs; r.rdy = rdy; r.we = we; r.addr = addr;
        r.wd = wd; r.dn = dn; r.er = er; r.hold = hold; r.wl = wl;
        tbl.push_back(r);
    endtask

    // Basic two-word frame, one byte per cycle; checksum byte supplied.
    task automatic add_basic(input logic [7:0] chkb, input bit good);
        add(1, 8'hA5, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        add(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        add(1, 8'h02, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        add(1, 8'h11, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        add(1, 8'h22, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        add(1, 8'h33, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        add(1, 8'h44, 0, 1, 1, 0, 32'h11223344, 0, 0, 1, 1);
        add(1, 8'h55, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        add(1, 8'h66, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        add(1, 8'h77, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        add(1, 8'h88, 0, 1, 1, 1, 32'h55667788, 0, 0, 1, 2);
        if (good) add(1, chkb, 0, 0, 0, 0, 0, 1, 0, 0, 2);
        else      add(1, chkb, 0, 0, 0, 0, 0, 0, 1, 1, 2);
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap_max);
        int gaps, n;
        gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (gaps) begin
            @(negedge clk);
            sif.in_valid = 1'b0;
        end
        @(negedge clk);
        sif.in_valid = 1'b1;
        sif.in_data  = d;
        n = 0;
        while (!sif.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("byte_accept_timeout", 32'(n), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sif.in_valid = 1'b0;
        end
    endtask

    task automatic do_restart();
        @(negedge clk);
        sif.in_valid = 1'b0;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic send_basic(input int gap_max);
        logic [7:0] b[11];
        b = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88};
        foreach (b[i]) send_byte(b[i], gap_max);
        send_byte(8'h8A, gap_max);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0]  x;
        logic [31:0] w;
        logic [31:0] exp_words[IM_DEPTH];
        int bad;

        sif.in_valid = 1'b0;
        sif.in_data  = 8'h00;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(sif.in_ready), 32'd1);
        chk("rst_im_we", 32'(im_we), 32'd0);
        chk("rst_im_addr", 32'(im_addr), 32'd0);
        chk("rst_im_wdata", im_wdata, 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_words_loaded", 32'(words_loaded), 32'd0);
        reset = 1'b0;

        // table: basic load, byte in DONE, restart, checksum error, restart
        add_basic(8'h8A, 1'b1);
        add(1, 8'hA5, 0, 0, 0, 0, 0, 1, 0, 0, 2);
        add(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 1, 2);
        add(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 1, 2);
        add_basic(8'h8B, 1'b0);
        add(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 1, 2);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            sif.in_valid = tbl[i].v;
            sif.in_data  = tbl[i].d;
            restart      = tbl[i].rs;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(sif.in_ready), 32'(tbl[i].rdy));
            chk($sformatf("v%0d_im_we", i), 32'(im_we), 32'(tbl[i].we));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].dn));
            chk($sformatf("v%0d_error", i), 32'(error), 32'(tbl[i].er));
            chk($sformatf("v%0d_cpu_hold", i), 32'(cpu_hold), 32'(tbl[i].hold));
            chk($sformatf("v%0d_words_loaded", i), 32'(words_loaded), 32'(tbl[i].wl));
            if (tbl[i].we) begin
                chk($sformatf("v%0d_im_addr", i), 32'(im_addr), 32'(tbl[i].addr));
                chk($sformatf("v%0d_im_wdata", i), im_wdata, tbl[i].wd);
            end
        end
        @(negedge clk);
        sif.in_valid = 1'b0;
        restart = 1'b0;

        // garbage before sync, then one-word frame (CHK = 01^DE^AD^BE^EF = 23)
        base = wr_data.size();
        send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h3C, 0);
        idle(2);
        chk("garbage_no_writes", 32'(wr_data.size()), 32'(base));
        chk("garbage_still_idle_ready", 32'(sif.in_ready), 32'd1);
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
        send_byte(8'h23, 0);
        idle(3);
        chk("garbage_frame_writes", 32'(wr_data.size()), 32'(base + 1));
        if (wr_data.size() == base + 1) begin
            chk("garbage_frame_addr", 32'(wr_addr[base]), 32'd0);
            chk("garbage_frame_data", wr_data[base], 32'hDEADBEEF);
        end
        chk("garbage_frame_done", 32'(done), 32'd1);
        chk("garbage_frame_wl", 32'(words_loaded), 32'd1);
        do_restart();

        // LEN = 0
        base = wr_data.size();
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        idle(2);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_no_writes", 32'(wr_data.size()), 32'(base));
        chk("len0_wl", 32'(words_loaded), 32'd0);
        do_restart();

        // LEN = 0x0401 is rejected right after LEN_LO
        send_byte(8'hA5, 0); send_byte(8'h04, 0); send_byte(8'h01, 0);
        idle(1);
        chk("len_over_error", 32'(error), 32'd1);
        chk("len_over_in_ready", 32'(sif.in_ready), 32'd0);
        chk("len_over_hold", 32'(cpu_hold), 32'd1);
        chk("len_over_no_writes", 32'(wr_data.size()), 32'(base));
        do_restart();
        chk("len_over_restart_error", 32'(error), 32'd0);

        // LEN = 1024 random words
        base = wr_data.size();
        x = 8'h04 ^ 8'h00;
        send_byte(8'hA5, 0); send_byte(8'h04, 0); send_byte(8'h00, 0);
        for (int i = 0; i < IM_DEPTH; i++) begin
            w = $urandom;
            exp_words[i] = w;
            for (int k = 3; k >= 0; k--) begin
                send_byte(w[k*8 +: 8], 0);
                x = x ^ w[k*8 +: 8];
            end
        end
        send_byte(x, 0);
        idle(3);
        chk("full_write_count", 32'(wr_data.size() - base), 32'(IM_DEPTH));
        bad = 0;
        if (wr_data.size() == base + IM_DEPTH) begin
            for (int i = 0; i < IM_DEPTH; i++) begin
                if (wr_addr[base + i] !== IM_AW'(i) || wr_data[base + i] !== exp_words[i]) bad++;
            end
            chk("full_last_addr", 32'(wr_addr[base + IM_DEPTH - 1]), 32'd1023);
            chk("full_last_data", wr_data[base + IM_DEPTH - 1], exp_words[IM_DEPTH - 1]);
        end
        chk("full_bad_words", 32'(bad), 32'd0);
        chk("full_done", 32'(done), 32'd1);
        chk("full_wl", 32'(words_loaded), 32'd1024);
        do_restart();

        // reset in the middle of word 1, then fresh frame (CHK = 01^CA^FE^BA^BE = 31)
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        send_byte(8'h55, 0); send_byte(8'h66, 0);
        @(negedge clk);
        sif.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_im_we", 32'(im_we), 32'd0);
        chk("midrst_im_addr", 32'(im_addr), 32'd0);
        chk("midrst_im_wdata", im_wdata, 32'd0);
        chk("midrst_wl", 32'(words_loaded), 32'd0);
        chk("midrst_hold", 32'(cpu_hold), 32'd1);
        chk("midrst_in_ready", 32'(sif.in_ready), 32'd1);
        reset = 1'b0;
        base = wr_data.size();
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'hCA, 0); send_byte(8'hFE, 0); send_byte(8'hBA, 0); send_byte(8'hBE, 0);
        send_byte(8'h31, 0);
        idle(3);
        chk("midrst_writes", 32'(wr_data.size()), 32'(base + 1));
        if (wr_data.size() == base + 1) begin
            chk("midrst_addr", 32'(wr_addr[base]), 32'd0);
            chk("midrst_data", wr_data[base], 32'hCAFEBABE);
        end
        chk("midrst_done", 32'(done), 32'd1);
        do_restart();

        // backpressure gaps on the basic frame
        base = wr_data.size();
        send_basic(3);
        idle(3);
        chk("gaps_writes", 32'(wr_data.size()), 32'(base + 2));
        if (wr_data.size() == base + 2) begin
            chk("gaps_addr0", 32'(wr_addr[base]), 32'd0);
            chk("gaps_data0", wr_data[base], 32'h11223344);
            chk("gaps_addr1", 32'(wr_addr[base + 1]), 32'd1);
            chk("gaps_data1", wr_data[base + 1], 32'h55667788);
        end
        chk("gaps_done", 32'(done), 32'd1);
        chk("gaps_hold", 32'(cpu_hold), 32'd0);

        // bytes offered in DONE are not consumed
        @(negedge clk);
        sif.in_valid = 1'b1;
        sif.in_data  = 8'hA5;
        repeat (3) @(negedge clk);
        chk("done_in_ready", 32'(sif.in_ready), 32'd0);
        chk("done_stays", 32'(done), 32'd1);
        chk("done_wl_kept", 32'(words_loaded), 32'd2);
        sif.in_valid = 1'b0;

        // restart and reset together: reset wins, lands in IDLE
        @(negedge clk);
        restart = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        reset = 1'b0;
        chk("rst_restart_wl", 32'(words_loaded), 32'd0);
        chk("rst_restart_hold", 32'(cpu_hold), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
